branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Sequences conditional-branch resolution for the 16-bit core. Accepts a decoded instruction,
//  stalls branches while a flag-writing ALU op is still in flight, then presents the held branch
//  to flag_rf and samples its condition result. A taken branch produces a one-cycle PC redirect
//  and a fixed-length pipeline flush. Taken/not-taken statistics counters are kept.
// PARAMETERS
//  FLAG_LAT      2   cycles from flag_wr_issue until flag_rf z/v/n are valid (1..7)
//  FLUSH_CYCLES  2   cycles flush stays high after a taken redirect (1..7)
//  PC_W          16  program-counter width
// PORTS
//  clk            in   1     core clock; all state updates on rising edge
//  rst_n          in   1     synchronous reset, active low
//  instr_valid    in   1     instr/instr_pc valid this cycle
//  instr          in   16    decoded instruction: [15:12] opcode, [10:8] cond, [7:0] signed offset
//  instr_pc       in   PC_W  address of instr
//  instr_ready    out  1     branch_ctrl accepts instr this cycle (valid & ready = accept)
//  flag_wr_issue  in   1     a flag-setting ALU op enters execute this cycle
//  cond_instr     out  16    instruction driven to flag_rf instr input
//  cond_true      in   1     flag_rf out (combinational from cond_instr and flags)
//  stall          out  1     hold fetch/decode
//  redirect       out  1     one-cycle pulse: load pc_target into PC
//  pc_target      out  PC_W  branch target, valid while redirect = 1
//  flush          out  1     squash younger instructions
//  taken_cnt      out  16    number of taken branches, saturating
//  nt_cnt         out  16    number of not-taken branches, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; flag_cnt=0; stall=0, redirect=0, flush=0, pc_target=0,
//   cond_instr=16'h0000, taken_cnt=0, nt_cnt=0. Reset mid-operation abandons the branch; no redirect.
//  flag_cnt: loads FLAG_LAT when flag_wr_issue=1, else decrements toward 0. Load beats decrement.
//  is_br = instr_valid & (instr[15:12]==`B). Non-branch instr are accepted in IDLE with no effect.
//  instr_ready = (state==IDLE) & ~(is_br & (flag_cnt!=0 | flag_wr_issue)).
//  stall = ~instr_ready & instr_valid, combinational.
//  FSM:
//   IDLE  : branch accepted -> latch instr into cond_instr and instr_pc -> EVAL.
//           Branch with flag_cnt!=0 or flag_wr_issue=1 -> stall and remain in IDLE.
//   EVAL  : exactly one cycle. Sample cond_true.
//           1 -> redirect=1 next cycle; pc_target = pc_l + 1 + sext(off) mod 2^PC_W;
//                taken_cnt++ ; move to FLUSH with flush_cnt=FLUSH_CYCLES.
//           0 -> nt_cnt++ ; return to IDLE; no redirect, no flush.
//   FLUSH : flush=1; redirect=1 only in the first FLUSH cycle; flush_cnt decrements;
//           at 1 -> IDLE. instr_ready=0 throughout.
//  Latency: accept to redirect is 2 edges. Taken branch occupies 2+FLUSH_CYCLES cycles;
//   not-taken branch occupies 2 cycles.
//  Counters saturate at 16'hFFFF and do not wrap.
//  cond_instr holds its last value outside EVAL. The flag_rf result is sampled only in EVAL.
//  Back-to-back branches: the second is accepted no earlier than the first return to IDLE.
//  flag_wr_issue asserted during EVAL or FLUSH still reloads flag_cnt.
//  Target arithmetic wraps: pc_l=16'hFFFF, off=+1 -> 16'h0001.
// TESTING
//  1 EQUAL taken: flag_rf z=1, branch cond `EQUAL, pc=16'h0010, off=8'h05 -> redirect pulse
//    2 cycles after accept, pc_target=16'h0016, flush high 2 cycles, taken_cnt=1.
//  2 LESS not-taken: n=1, v=1, pc=16'h0020 -> no redirect, no flush, nt_cnt=1,
//    instr_ready back to 1 after 2 cycles.
//  3 Flag hazard: flag_wr_issue and branch in the same cycle -> stall=1 for FLAG_LAT+1 cycles.
//    Then the branch is accepted and evaluated on the updated flags
//    (GREATER, z=0, n=0, v=0 -> taken).
//  4 Negative offset and wrap: pc=16'h0002, off=8'hFB -> pc_target=16'hFFFE.
//    pc=16'hFFFF, off=8'h01 -> pc_target=16'h0001.
//  5 Reset mid-op: rst_n=0 during EVAL -> next cycle all outputs 0, counters 0, no redirect.
//    Reset during FLUSH -> flush drops after that edge.
//  6 Saturation: force taken_cnt=16'hFFFE, run 3 taken branches -> taken_cnt=16'hFFFF.

Source files
------------

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - conditional branch sequencer: flag-hazard stall, evaluate, redirect, flush
// One branch in flight at a time; cond_true from flag_rf is sampled only in the single EVAL cycle.
module branch_ctrl #(
   parameter int unsigned FLAG_LAT     = 2,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned PC_W         = 16,
   parameter logic [3:0]  OP_B         = 4'hB
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            instr_valid_i,
   input  logic [15:0]     instr_i,
   input  logic [PC_W-1:0] instr_pc_i,
   output logic            instr_ready_o,
   input  logic            flag_wr_issue_i,
   output logic [15:0]     cond_instr_o,
   input  logic            cond_true_i,
   output logic            stall_o,
   output logic            redirect_o,
   output logic [PC_W-1:0] pc_target_o,
   output logic            flush_o,
   output logic [15:0]     taken_cnt_o,
   output logic [15:0]     nt_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EVAL  = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   localparam logic [2:0] FLAG_INIT  = 3'(FLAG_LAT);
   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

   state_e          state_q, state_d;
   logic [2:0]      flag_cnt_q, flag_cnt_d;
   logic [2:0]      flush_cnt_q, flush_cnt_d;
   logic [15:0]     cond_instr_q, cond_instr_d;
   logic [PC_W-1:0] pc_l_q, pc_l_d;
   logic [PC_W-1:0] pc_target_q, pc_target_d;
   logic [15:0]     taken_cnt_q, taken_cnt_d;
   logic [15:0]     nt_cnt_q, nt_cnt_d;

   logic            is_br;
   logic            ready;
   logic [PC_W-1:0] off_ext;

   // A branch may not enter while flags are still being produced, including the issuing cycle.
   assign is_br   = instr_valid_i & (instr_i[15:12] == OP_B);
   assign ready   = (state_q == S_IDLE) & ~(is_br & ((flag_cnt_q != 3'd0) | flag_wr_issue_i));
   assign off_ext = {{(PC_W-8){cond_instr_q[7]}}, cond_instr_q[7:0]};

   assign instr_ready_o = ready;
   assign stall_o       = ~ready & instr_valid_i;
   assign cond_instr_o  = cond_instr_q;
   assign pc_target_o   = pc_target_q;
   assign flush_o       = (state_q == S_FLUSH);
   assign redirect_o    = (state_q == S_FLUSH) & (flush_cnt_q == FLUSH_INIT);
   assign taken_cnt_o   = taken_cnt_q;
   assign nt_cnt_o      = nt_cnt_q;

   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      cond_instr_d = cond_instr_q;
      pc_l_d       = pc_l_q;
      pc_target_d  = pc_target_q;
      taken_cnt_d  = taken_cnt_q;
      nt_cnt_d     = nt_cnt_q;

      if (flag_wr_issue_i) begin
         flag_cnt_d = FLAG_INIT;
      end else if (flag_cnt_q != 3'd0) begin
         flag_cnt_d = flag_cnt_q - 3'd1;
      end else begin
         flag_cnt_d = 3'd0;
      end

      case (state_q)
         S_IDLE: begin
            if (is_br & ready) begin
               cond_instr_d = instr_i;
               pc_l_d       = instr_pc_i;
               state_d      = S_EVAL;
            end
         end
         S_EVAL: begin
            if (cond_true_i) begin
               pc_target_d = pc_l_q + PC_W'(1) + off_ext;
               taken_cnt_d = (taken_cnt_q == 16'hFFFF) ? taken_cnt_q : taken_cnt_q + 16'd1;
               flush_cnt_d = FLUSH_INIT;
               state_d     = S_FLUSH;
            end else begin
               nt_cnt_d = (nt_cnt_q == 16'hFFFF) ? nt_cnt_q : nt_cnt_q + 16'd1;
               state_d  = S_IDLE;
            end
         end
         S_FLUSH: begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q == 3'd1) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         flag_cnt_q   <= 3'd0;
         flush_cnt_q  <= 3'd0;
         cond_instr_q <= 16'h0000;
         pc_l_q       <= '0;
         pc_target_q  <= '0;
         taken_cnt_q  <= 16'd0;
         nt_cnt_q     <= 16'd0;
      end else begin
         state_q      <= state_d;
         flag_cnt_q   <= flag_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         cond_instr_q <= cond_instr_d;
         pc_l_q       <= pc_l_d;
         pc_target_q  <= pc_target_d;
         taken_cnt_q  <= taken_cnt_d;
         nt_cnt_q     <= nt_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl against a cycle-timeline model
module tb_branch_ctrl;

   localparam int         FLAG_LAT     = 2;
   localparam int         FLUSH_CYCLES = 2;
   localparam logic [3:0] OP_B         = 4'hB;
   localparam logic [2:0] C_EQ = 3'd0, C_NE = 3'd1, C_LT = 3'd2, C_GT = 3'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic [15:0] instr_pc = 16'h0000;
   logic        flag_wr_issue = 1'b0;
   logic        instr_ready, cond_true, stall, redirect, flush;
   logic [15:0] cond_instr, pc_target, taken_cnt, nt_cnt;
   logic        fz = 1'b0, fn = 1'b0, fv = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_red = 0, n_fl = 0, n_stall = 0;

   always #5 clk = ~clk;

   function automatic logic cond_eval(input logic [2:0] c, input logic z, input logic n, input logic v);
      case (c)
         C_EQ:    return z;
         C_NE:    return ~z;
         C_LT:    return n ^ v;
         C_GT:    return ~z & ~(n ^ v);
         3'd7:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign cond_true = cond_eval(cond_instr[10:8], fz, fn, fv);

   branch_ctrl #(.FLAG_LAT(FLAG_LAT), .FLUSH_CYCLES(FLUSH_CYCLES), .PC_W(16), .OP_B(OP_B)) dut (
      .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_i(instr),
      .instr_pc_i(instr_pc), .instr_ready_o(instr_ready), .flag_wr_issue_i(flag_wr_issue),
      .cond_instr_o(cond_instr), .cond_true_i(cond_true), .stall_o(stall),
      .redirect_o(redirect), .pc_target_o(pc_target), .flush_o(flush),
      .taken_cnt_o(taken_cnt), .nt_cnt_o(nt_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: timeline of cycle numbers at which each phase of the current branch happens.
   bit          m_on = 1'b0;
   int          m_idle_at = 0, m_eval_at = -1, m_red_at = -1, m_fl_from = -1, m_fl_to = -2;
   int          m_last_iss = -1000;
   logic [15:0] m_ci = 16'h0000, m_pc = 16'h0000, m_pct = 16'h0000, m_tk = 16'h0000, m_nt = 16'h0000;

   always @(negedge clk) begin : compare
      int   fcnt;
      logic isb, e_rdy;
      cyc++;
      fcnt  = FLAG_LAT + 1 - (cyc - m_last_iss);
      if (fcnt < 0) fcnt = 0;
      isb   = instr_valid && (instr[15:12] == OP_B);
      e_rdy = (cyc >= m_idle_at) && !(isb && (fcnt != 0 || flag_wr_issue));
      if (m_on) begin
         chk("instr_ready", instr_ready, e_rdy);
         chk("stall", stall, !e_rdy && instr_valid);
         chk("redirect", redirect, cyc == m_red_at);
         chk("flush", flush, cyc >= m_fl_from && cyc <= m_fl_to);
         chk("pc_target", pc_target, m_pct);
         chk("cond_instr", cond_instr, m_ci);
         chk("taken_cnt", taken_cnt, m_tk);
         chk("nt_cnt", nt_cnt, m_nt);
         n_red   += int'(redirect);
         n_fl    += int'(flush);
         n_stall += int'(stall);
      end
      if (!rst_n) begin
         m_on = 1'b1; m_idle_at = cyc + 1; m_eval_at = -1; m_red_at = -1;
         m_fl_from = -1; m_fl_to = -2; m_last_iss = -1000;
         m_ci = 16'h0000; m_pc = 16'h0000; m_pct = 16'h0000; m_tk = 16'h0000; m_nt = 16'h0000;
      end else begin
         if (flag_wr_issue) m_last_iss = cyc;
         if (cyc == m_eval_at) begin
            if (cond_eval(m_ci[10:8], fz, fn, fv)) begin
               m_pct     = m_pc + 16'd1 + {{8{m_ci[7]}}, m_ci[7:0]};
               m_tk      = (m_tk == 16'hFFFF) ? m_tk : m_tk + 16'd1;
               m_red_at  = cyc + 1;
               m_fl_from = cyc + 1;
               m_fl_to   = cyc + FLUSH_CYCLES;
               m_idle_at = cyc + 1 + FLUSH_CYCLES;
            end else begin
               m_nt      = (m_nt == 16'hFFFF) ? m_nt : m_nt + 16'd1;
               m_idle_at = cyc + 1;
            end
         end
         if (e_rdy && isb) begin
            m_ci = instr; m_pc = instr_pc; m_eval_at = cyc + 1; m_idle_at = cyc + 2;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      instr_valid = 1'b0;
      flag_wr_issue = 1'b0;
      repeat (n) step();
   endtask

   // Holds a branch until accepted; with iss, new flags {z,n,v} land FLAG_LAT cycles later.
   task automatic send_br(input logic [2:0] c, input logic [7:0] off, input logic [15:0] pc,
                          input logic iss, input logic [2:0] nf);
      logic acc, r;
      acc = 1'b0;
      instr_valid = 1'b1; instr = {OP_B, 1'b0, c, off}; instr_pc = pc; flag_wr_issue = iss;
      for (int i = 0; i < 20 && !acc; i++) begin
         #1 r = instr_ready;
         step();
         acc = r;
         flag_wr_issue = 1'b0;
         if (iss && i == FLAG_LAT - 1) {fz, fn, fv} = nf;
      end
      instr_valid = 1'b0;
      chk("accept_in_time", acc, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_taken", taken_cnt, 16'h0000);
      chk("rst_pc_target", pc_target, 16'h0000);
      chk("rst_ready", instr_ready, 1'b1);
      step();

      // Taken EQUAL
      {fz, fn, fv} = 3'b100;
      n_red = 0; n_fl = 0;
      send_br(C_EQ, 8'h05, 16'h0010, 1'b0, 3'b000);
      @(negedge clk);
      chk("t1_no_early_redirect", redirect, 1'b0);
      @(negedge clk);
      chk("t1_redirect", redirect, 1'b1);
      chk("t1_target", pc_target, 16'h0016);
      chk("t1_taken", taken_cnt, 16'd1);
      idle(4);
      chk("t1_redirect_count", n_red, 1);
      chk("t1_flush_len", n_fl, 2);

      // Not-taken LESS
      {fz, fn, fv} = 3'b011;
      n_red = 0; n_fl = 0;
      send_br(C_LT, 8'h10, 16'h0020, 1'b0, 3'b000);
      @(negedge clk);
      chk("t2_busy", instr_ready, 1'b0);
      step();
      @(negedge clk);
      chk("t2_ready_back", instr_ready, 1'b1);
      chk("t2_nt", nt_cnt, 16'd1);
      idle(2);
      chk("t2_no_redirect", n_red, 0);
      chk("t2_no_flush", n_fl, 0);

      // Flag hazard, then GREATER on updated flags; non-branch passes while flags pending
      {fz, fn, fv} = 3'b100;
      instr_valid = 1'b1; instr = 16'h1234; flag_wr_issue = 1'b1;
      step();
      idle(4);
      n_stall = 0; n_red = 0;
      send_br(C_GT, 8'h03, 16'h0100, 1'b1, 3'b000);
      idle(6);
      chk("t3_stall_len", n_stall, FLAG_LAT + 1);
      chk("t3_taken", taken_cnt, 16'd2);
      chk("t3_target", pc_target, 16'h0104);
      chk("t3_redirect_count", n_red, 1);

      // Negative offset and wrap
      {fz, fn, fv} = 3'b100;
      send_br(C_EQ, 8'hFB, 16'h0002, 1'b0, 3'b000);
      idle(5);
      chk("t4_neg_target", pc_target, 16'hFFFE);
      send_br(C_EQ, 8'h01, 16'hFFFF, 1'b0, 3'b000);
      idle(5);
      chk("t4_wrap_target", pc_target, 16'h0001);
      chk("t4_taken", taken_cnt, 16'd4);

      // Reset during EVAL
      n_red = 0;
      send_br(C_NE, 8'h22, 16'h0300, 1'b0, 3'b000);
      {fz, fn, fv} = 3'b000;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_redirect", redirect, 1'b0);
      chk("t5_taken", taken_cnt, 16'd0);
      chk("t5_cond_instr", cond_instr, 16'h0000);
      idle(4);
      chk("t5_no_redirect", n_red, 0);

      // Reset during FLUSH
      send_br(C_NE, 8'h04, 16'h0400, 1'b0, 3'b000);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_flush_drop", flush, 1'b0);
      idle(3);

      // Saturation
      force dut.taken_cnt_q = 16'hFFFE;
      m_tk = 16'hFFFE;
      step();
      release dut.taken_cnt_q;
      step();
      for (int k = 0; k < 3; k++) begin
         send_br(C_NE, 8'h01, 16'h0500, 1'b0, 3'b000);
         idle(5);
      end
      chk("t6_saturated", taken_cnt, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
